// File: rtl/demux_1to4_20bit.sv
// demux_1to4_20bit: registered 1-to-4 demux for WIDTH-bit words with
// valid/ready on the input and on each of the four output channels.
//
// Ports:
//   Clk, Reset_n          clock, asynchronous active-low reset
//   In, InValid, InReady  input word handshake
//   Select                destination channel (ignored with DEMUX_RR_EN)
//   Dest                  channel that receives the next accepted word
//   Out0..3, Valid0..3    channel holding registers
//   Ready0..3             channel consumer accepts
//
// Optional feature macro: DEMUX_RR_EN
//   defined   -> a 2-bit round-robin pointer drives Dest, advancing
//                on every accept; Select is ignored.
//   undefined -> Dest follows Select combinationally.

module demux_1to4_20bit #(
   parameter int WIDTH = 20
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic [WIDTH-1:0] In,
   input  logic             InValid,
   output logic             InReady,
   input  logic [1:0]       Select,
   output logic [1:0]       Dest,
   output logic [WIDTH-1:0] Out0,
   output logic [WIDTH-1:0] Out1,
   output logic [WIDTH-1:0] Out2,
   output logic [WIDTH-1:0] Out3,
   output logic             Valid0,
   output logic             Valid1,
   output logic             Valid2,
   output logic             Valid3,
   input  logic             Ready0,
   input  logic             Ready1,
   input  logic             Ready2,
   input  logic             Ready3
);

   // Per-channel holding registers
   logic [WIDTH-1:0] out0_q, out0_d;
   logic [WIDTH-1:0] out1_q, out1_d;
   logic [WIDTH-1:0] out2_q, out2_d;
   logic [WIDTH-1:0] out3_q, out3_d;
   logic [3:0]       valid_q, valid_d;

   logic [3:0] ready_vec;
   logic [3:0] load;
   logic [3:0] consume;
   logic       accept;
   logic [1:0] dest;

`ifdef DEMUX_RR_EN
   logic [1:0] rr_q, rr_d;

   always_comb begin
      dest = rr_q;
   end

   // Pointer moves only on accept; a stalled channel holds it in place
   always_comb begin
      rr_d = rr_q;
      if (accept) begin
         rr_d = rr_q + 2'd1;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         rr_q <= 2'd0;
      end else begin
         rr_q <= rr_d;
      end
   end
`else
   always_comb begin
      dest = Select;
   end
`endif

   assign ready_vec = {Ready3, Ready2, Ready1, Ready0};

   // A full destination may still take a word if it drains this cycle
   always_comb begin
      InReady = !valid_q[dest] || ready_vec[dest];
      accept  = InValid && InReady;
   end

   always_comb begin
      load    = 4'b0000;
      consume = valid_q & ready_vec;
      if (accept) begin
         load[dest] = 1'b1;
      end
   end

   // Load wins over consume so a same-cycle drain/fill keeps Valid high
   always_comb begin
      valid_d = valid_q;
      for (int n = 0; n < 4; n++) begin
         if (load[n]) begin
            valid_d[n] = 1'b1;
         end else if (consume[n]) begin
            valid_d[n] = 1'b0;
         end
      end
   end

   // Data is kept after consume; only a load overwrites it
   always_comb begin
      out0_d = out0_q;
      out1_d = out1_q;
      out2_d = out2_q;
      out3_d = out3_q;
      if (load[0]) begin
         out0_d = In;
      end
      if (load[1]) begin
         out1_d = In;
      end
      if (load[2]) begin
         out2_d = In;
      end
      if (load[3]) begin
         out3_d = In;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         out0_q  <= '0;
         out1_q  <= '0;
         out2_q  <= '0;
         out3_q  <= '0;
         valid_q <= 4'b0000;
      end else begin
         out0_q  <= out0_d;
         out1_q  <= out1_d;
         out2_q  <= out2_d;
         out3_q  <= out3_d;
         valid_q <= valid_d;
      end
   end

   assign Dest   = dest;
   assign Out0   = out0_q;
   assign Out1   = out1_q;
   assign Out2   = out2_q;
   assign Out3   = out3_q;
   assign Valid0 = valid_q[0];
   assign Valid1 = valid_q[1];
   assign Valid2 = valid_q[2];
   assign Valid3 = valid_q[3];

endmodule
